// File: rtl/seg_pattern_decoder.sv
// Seven-segment readback monitor: debounces an active-low segment bus and offers each new decoded code over valid/ready.
// Optional macro SEG_DECODE_SYNC_EN selects a two-flop input synchronizer instead of a single sample register.
module seg_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hex_in,
    output logic [3:0] code_out,
    output logic [7:0] seg_raw,
    output logic       code_err,
    output logic       code_valid,
    input  logic       code_ready
);

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_WATCH,
        ST_HOLD
    } state_e;

    logic [SEG_W-1:0]  smp_q;
    logic [SEG_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEG_W-1:0]  last_q;
    logic              last_vld_q;
    logic [SEG_W-1:0]  raw_q;
    logic [CODE_W-1:0] code_q;
    logic              err_q;
    state_e            state_q;
    logic [CODE_W-1:0] dec_code_c;
    logic              dec_err_c;
    logic              qualify_c;

`ifdef SEG_DECODE_SYNC_EN
    logic [SEG_W-1:0] s1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= '1;
            smp_q <= '1;
        end else begin
            s1_q  <= hex_in;
            smp_q <= s1_q;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_q <= '1;
        end else begin
            smp_q <= hex_in;
        end
    end
`endif

    // Stability tracker: restart on any change, saturate once the hold time is met.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (smp_q != cand_q) begin
            cand_d = smp_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= '1;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        dec_code_c = '0;
        dec_err_c  = 1'b0;
        case (cand_q)
            8'hC0: dec_code_c = 4'h0;
            8'hF9: dec_code_c = 4'h1;
            8'hA4: dec_code_c = 4'h2;
            8'hB0: dec_code_c = 4'h3;
            8'h99: dec_code_c = 4'h4;
            8'h92: dec_code_c = 4'h5;
            8'h82: dec_code_c = 4'h6;
            8'hF8: dec_code_c = 4'h7;
            8'h80: dec_code_c = 4'h8;
            8'h90: dec_code_c = 4'h9;
            8'hFF: dec_code_c = 4'hA;
            8'hBF: dec_code_c = 4'hB;
            8'h8C: dec_code_c = 4'hC;
            8'h79: dec_code_c = 4'hD;
            8'h24: dec_code_c = 4'hE;
            8'h8E: dec_code_c = 4'hF;
            default: dec_err_c = 1'b1;
        endcase
    end

    // Only patterns that differ from the last offer (or the first one after reset) qualify.
    assign qualify_c = (smp_q == cand_q) && (cnt_q == CNT_MAX) &&
                       (!last_vld_q || (cand_q != last_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WATCH;
            raw_q      <= '1;
            code_q     <= '0;
            err_q      <= 1'b0;
            last_q     <= '1;
            last_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WATCH: begin
                    if (qualify_c) begin
                        raw_q      <= cand_q;
                        last_q     <= cand_q;
                        code_q     <= dec_code_c;
                        err_q      <= dec_err_c;
                        last_vld_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (code_ready) begin
                        state_q <= ST_WATCH;
                    end
                end
                default: state_q <= ST_WATCH;
            endcase
        end
    end

    assign code_valid = (state_q == ST_HOLD);
    assign code_out   = code_q;
    assign seg_raw    = raw_q;
    assign code_err   = err_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed plus randomized bench for seg_pattern_decoder against a run-length reference model.
module tb_seg_pattern_decoder;

    localparam int unsigned STABLE = 4;
`ifdef SEG_DECODE_SYNC_EN
    localparam int unsigned LAT = STABLE + 3;
`else
    localparam int unsigned LAT = STABLE + 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hex_in;
    logic [3:0] code_out;
    logic [7:0] seg_raw;
    logic       code_err;
    logic       code_valid;
    logic       code_ready;

    seg_pattern_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .code_out   (code_out),
        .seg_raw    (seg_raw),
        .code_err   (code_err),
        .code_valid (code_valid),
        .code_ready (code_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] pat_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hFF, 8'hBF, 8'h8C, 8'h79, 8'h24, 8'h8E};

    // Reference model: input pipeline plus run length of the current sampled value.
    logic [7:0]  m_s1, m_smp, m_run_val, m_last, m_raw;
    int unsigned m_run_len;
    bit          m_last_vld, m_valid, m_err;
    logic [3:0]  m_code;

    logic [12:0] xq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [7:0] p, output logic [3:0] c, output bit e);
        c = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pat_tbl[i] == p) begin
                c = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    task automatic model_reset();
        m_s1 = 8'hFF; m_smp = 8'hFF; m_run_val = 8'hFF; m_run_len = 1;
        m_last = 8'hFF; m_last_vld = 1'b0; m_valid = 1'b0;
        m_raw = 8'hFF; m_code = 4'h0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] h, input logic r);
        logic [7:0] o_smp;
        logic [3:0] c;
        bit         e;
        bit         qual;
        o_smp = m_smp;
        qual  = (o_smp == m_run_val) && (m_run_len >= STABLE) &&
                (!m_last_vld || (m_run_val != m_last));
        if (m_valid) begin
            if (r) m_valid = 1'b0;
        end else if (qual) begin
            ref_decode(m_run_val, c, e);
            m_raw = m_run_val; m_last = m_run_val; m_last_vld = 1'b1;
            m_code = c; m_err = e; m_valid = 1'b1;
        end
        if (o_smp == m_run_val) begin
            if (m_run_len < 1000) m_run_len++;
        end else begin
            m_run_val = o_smp;
            m_run_len = 1;
        end
`ifdef SEG_DECODE_SYNC_EN
        m_smp = m_s1;
        m_s1  = h;
`else
        m_smp = h;
`endif
    endtask

    // One clock: drive at negedge, record transfers, step model, compare just after the edge.
    task automatic cyc(input logic [7:0] h, input logic r);
        hex_in     = h;
        code_ready = r;
        if (code_valid && r) xq.push_back({code_err, seg_raw, code_out});
        @(posedge clk);
        model_edge(h, r);
        #1;
        chk("valid", 32'(code_valid), 32'(m_valid));
        if (m_valid) begin
            chk("code", 32'(code_out), 32'(m_code));
            chk("raw",  32'(seg_raw),  32'(m_raw));
            chk("err",  32'(code_err), 32'(m_err));
        end
        @(negedge clk);
    endtask

    task automatic chk_x(input string tag, input int idx, input logic [12:0] exp);
        logic [12:0] got;
        got = (idx < xq.size()) ? xq[idx] : 13'h1FFF;
        chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [7:0] p;
        int unsigned hold;
        logic r;

        reset = 1'b1; hex_in = 8'hFF; code_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_code",  32'(code_out),   32'd0);
        chk("rst_raw",   32'(seg_raw),    32'hFF);
        chk("rst_err",   32'(code_err),   32'd0);
        reset = 1'b0;

        // Blank after reset is offered exactly once.
        xq.delete();
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(8'hFF, 1'b1);
            if (code_valid && first < 0) first = i;
        end
        chk("blank_lat", 32'(first), 32'(STABLE));
        chk("blank_n", 32'(xq.size()), 32'd1);
        chk_x("blank_x", 0, {1'b0, 8'hFF, 4'hA});

        // Sweep every table entry.
        xq.delete();
        for (int k = 0; k < 16; k++) repeat (10) cyc(pat_tbl[k], 1'b1);
        repeat (10) cyc(8'h8E, 1'b1);
        chk("sweep_n", 32'(xq.size()), 32'd16);
        for (int k = 0; k < 16; k++) chk_x("sweep_x", k, {1'b0, pat_tbl[k], 4'(k)});

        // Patterns outside the table.
        xq.delete();
        repeat (10) cyc(8'h7F, 1'b1);
        repeat (12) cyc(8'h55, 1'b1);
        chk("err_n", 32'(xq.size()), 32'd2);
        chk_x("err_x0", 0, {1'b1, 8'h7F, 4'h0});
        chk_x("err_x1", 1, {1'b1, 8'h55, 4'h0});

        // Short glitch is rejected and the restored pattern is not re-offered.
        xq.delete();
        repeat (12) cyc(8'hC0, 1'b1);
        repeat (3)  cyc(8'hF9, 1'b1);
        repeat (12) cyc(8'hC0, 1'b1);
        chk("glitch_n", 32'(xq.size()), 32'd1);
        chk_x("glitch_x", 0, {1'b0, 8'hC0, 4'h0});

        // Back-pressure: intermediate pattern lost, latest offered right after transfer.
        repeat (12) cyc(8'hFF, 1'b1);
        xq.delete();
        repeat (10) cyc(8'hC0, 1'b0);
        repeat (10) cyc(8'hF9, 1'b0);
        repeat (10) cyc(8'hA4, 1'b0);
        cyc(8'hA4, 1'b1);
        chk("bp_gap", 32'(code_valid), 32'd0);
        cyc(8'hA4, 1'b1);
        chk("bp_next_v", 32'(code_valid), 32'd1);
        chk("bp_next_c", 32'(code_out), 32'd2);
        repeat (5) cyc(8'hA4, 1'b1);
        chk("bp_n", 32'(xq.size()), 32'd2);
        chk_x("bp_x0", 0, {1'b0, 8'hC0, 4'h0});
        chk_x("bp_x1", 1, {1'b0, 8'hA4, 4'h2});

        // Asynchronous reset in HOLD discards the offer.
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            cyc(8'h92, 1'b0);
            if (code_valid) first = i;
        end
        chk("hold_reached", 32'(code_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(code_valid), 32'd0);
        chk("arst_raw",   32'(seg_raw),    32'hFF);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        xq.delete();
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(8'h92, 1'b1);
            if (code_valid && first < 0) first = i;
        end
        chk("arst_lat", 32'(first), 32'(LAT));
        chk("arst_n", 32'(xq.size()), 32'd1);
        chk_x("arst_x", 0, {1'b0, 8'h92, 4'h5});

        // Randomized patterns, hold times and ready against the model.
        for (int s = 0; s < 60; s++) begin
            p    = ($urandom_range(0, 3) != 0) ? pat_tbl[$urandom_range(0, 15)] : 8'($urandom);
            hold = $urandom_range(1, 12);
            for (int c = 0; c < int'(hold); c++) begin
                r = ($urandom_range(0, 3) != 0);
                cyc(p, r);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
